stream_serializer: RTL and testbench



---
 rtl/stream_serializer.sv | 124 ++++++++++++
 tb/tb_stream_serializer.sv | 223 ++++++++++++++++++++++
 2 files changed

// File: rtl/stream_serializer.sv
`default_nettype none
// ============================================================================
// Module      : stream_serializer
// Description : Parallel-in / serial-out shift register with valid/ready
//               handshakes on both sides. One DataWidth word is accepted and
//               emitted as NumBeats = DataWidth/BeatWidth narrow beats, with
//               the final beat flagged by ser_last_o. A new word can be
//               accepted in the same cycle as the last beat handshake, so
//               back-to-back words stream without bubbles.
// Ports       : clk_i, rst_i         - clock, synchronous active-high reset
//               par_valid_i/par_ready_o/par_data_i - parallel word input
//               ser_valid_o/ser_ready_i/ser_data_o - serial beat output
//               ser_last_o           - current beat is the last of the word
//               beat_idx_o           - index of the current beat
//               busy_o               - a word is being shifted out
// Revision    : 1.0 - initial release
// ============================================================================
module stream_serializer #(
    parameter int DataWidth = 64,
    parameter int BeatWidth = 8,
    parameter bit MsbFirst  = 1'b0
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic                 par_valid_i,
    output logic                 par_ready_o,
    input  logic [DataWidth-1:0] par_data_i,
    output logic                 ser_valid_o,
    input  logic                 ser_ready_i,
    output logic [BeatWidth-1:0] ser_data_o,
    output logic                 ser_last_o,
    output logic [((DataWidth/BeatWidth) > 1 ? $clog2(DataWidth/BeatWidth) : 1)-1:0] beat_idx_o,
    output logic                 busy_o
);

    localparam int NumBeats = DataWidth / BeatWidth;
    localparam int CntWidth = (NumBeats > 1) ? $clog2(NumBeats) : 1;
    localparam logic [CntWidth-1:0] c_LAST_IDX = CntWidth'(NumBeats - 1);

    // The word must split into a whole number of beats.
    generate
        if ((DataWidth % BeatWidth) != 0 || BeatWidth < 1) begin : g_width_check
            $error("stream_serializer: DataWidth must be an integer multiple of BeatWidth");
        end
    endgenerate

    typedef enum logic [0:0] {
        S_IDLE  = 1'b0,
        S_SHIFT = 1'b1
    } state_t;

    state_t                r_state;
    logic [DataWidth-1:0]  r_shift;
    logic [CntWidth-1:0]   r_count;

    logic [DataWidth-1:0]  w_shift_next;
    logic [BeatWidth-1:0]  w_beat;
    logic                  w_last;
    logic                  w_par_hs;

    // Output end of the shift register depends on the beat order; the word
    // always moves toward that end with zeros filling in behind it.
    generate
        if (MsbFirst) begin : g_msb_first
            assign w_beat       = r_shift[DataWidth-1 -: BeatWidth];
            assign w_shift_next = r_shift << BeatWidth;
        end else begin : g_lsb_first
            assign w_beat       = r_shift[BeatWidth-1:0];
            assign w_shift_next = r_shift >> BeatWidth;
        end
    endgenerate

    // Gated by state so a single-beat configuration does not flag last in IDLE.
    assign w_last = (r_state == S_SHIFT) && (r_count == c_LAST_IDX);

    // Only combinational path from the serial side: the last beat being taken
    // frees the register for the next word in the same cycle.
    assign par_ready_o = (r_state == S_IDLE) || (w_last && ser_ready_i);
    assign w_par_hs    = par_valid_i && par_ready_o;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state <= S_IDLE;
            r_shift <= '0;
            r_count <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_par_hs) begin
                        r_shift <= par_data_i;
                        r_count <= '0;
                        r_state <= S_SHIFT;
                    end
                end
                S_SHIFT: begin
                    if (ser_ready_i) begin
                        if (w_last) begin
                            r_count <= '0;
                            if (w_par_hs) begin
                                r_shift <= par_data_i;
                            end else begin
                                r_state <= S_IDLE;
                            end
                        end else begin
                            r_shift <= w_shift_next;
                            r_count <= r_count + CntWidth'(1);
                        end
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign ser_valid_o = (r_state == S_SHIFT);
    assign busy_o      = (r_state == S_SHIFT);
    assign ser_data_o  = w_beat;
    assign ser_last_o  = w_last;
    assign beat_idx_o  = r_count;

endmodule
`default_nettype wire

// File: tb/tb_stream_serializer.sv
`default_nettype none
// ============================================================================
// Module      : tb_stream_serializer
// Description : Directed testbench for stream_serializer. Three instances:
//               A = 32/8 LSB-first, B = 32/8 MSB-first, C = 8/8 degenerate.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_stream_serializer;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    // A : LSB first
    logic        a_pv, a_pr, a_sv, a_sr, a_last, a_busy;
    logic [31:0] a_pd;
    logic [7:0]  a_sd;
    logic [1:0]  a_idx;
    // B : MSB first
    logic        b_pv, b_pr, b_sv, b_sr, b_last, b_busy;
    logic [31:0] b_pd;
    logic [7:0]  b_sd;
    logic [1:0]  b_idx;
    // C : single beat
    logic        c_pv, c_pr, c_sv, c_sr, c_last, c_busy;
    logic [7:0]  c_pd;
    logic [7:0]  c_sd;
    logic [0:0]  c_idx;

    stream_serializer #(.DataWidth(32), .BeatWidth(8), .MsbFirst(1'b0)) u_a (
        .clk_i(clk), .rst_i(rst),
        .par_valid_i(a_pv), .par_ready_o(a_pr), .par_data_i(a_pd),
        .ser_valid_o(a_sv), .ser_ready_i(a_sr), .ser_data_o(a_sd),
        .ser_last_o(a_last), .beat_idx_o(a_idx), .busy_o(a_busy)
    );

    stream_serializer #(.DataWidth(32), .BeatWidth(8), .MsbFirst(1'b1)) u_b (
        .clk_i(clk), .rst_i(rst),
        .par_valid_i(b_pv), .par_ready_o(b_pr), .par_data_i(b_pd),
        .ser_valid_o(b_sv), .ser_ready_i(b_sr), .ser_data_o(b_sd),
        .ser_last_o(b_last), .beat_idx_o(b_idx), .busy_o(b_busy)
    );

    stream_serializer #(.DataWidth(8), .BeatWidth(8), .MsbFirst(1'b0)) u_c (
        .clk_i(clk), .rst_i(rst),
        .par_valid_i(c_pv), .par_ready_o(c_pr), .par_data_i(c_pd),
        .ser_valid_o(c_sv), .ser_ready_i(c_sr), .ser_data_o(c_sd),
        .ser_last_o(c_last), .beat_idx_o(c_idx), .busy_o(c_busy)
    );

    task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Advance one clock; inputs are driven and outputs sampled 1 time unit
    // after the rising edge, clear of the edge itself.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    // Check one serial beat of instance A currently on the outputs.
    task automatic chk_a(input string tag, input logic [7:0] d, input logic [1:0] idx,
                         input logic last, input logic pr);
        check_eq({tag, ".valid"}, 64'(a_sv), 64'(1'b1));
        check_eq({tag, ".data"},  64'(a_sd), 64'(d));
        check_eq({tag, ".idx"},   64'(a_idx), 64'(idx));
        check_eq({tag, ".last"},  64'(a_last), 64'(last));
        check_eq({tag, ".pready"}, 64'(a_pr), 64'(pr));
    endtask

    task automatic chk_a_idle(input string tag);
        check_eq({tag, ".valid"}, 64'(a_sv), 64'(1'b0));
        check_eq({tag, ".busy"},  64'(a_busy), 64'(1'b0));
        check_eq({tag, ".idx"},   64'(a_idx), 64'(2'd0));
        check_eq({tag, ".last"},  64'(a_last), 64'(1'b0));
        check_eq({tag, ".pready"}, 64'(a_pr), 64'(1'b1));
    endtask

    initial begin
        logic [7:0] exp_a [8];
        logic [7:0] exp_b [4];

        a_pv = 0; a_pd = '0; a_sr = 1;
        b_pv = 0; b_pd = '0; b_sr = 1;
        c_pv = 0; c_pd = '0; c_sr = 1;
        rst  = 1;
        step(); step();
        rst = 0;
        step();

        // ---------------- reset state ----------------
        settle();
        chk_a_idle("rstA");
        check_eq("rstB.valid", 64'(b_sv), 64'(1'b0));
        check_eq("rstB.pready", 64'(b_pr), 64'(1'b1));
        check_eq("rstC.valid", 64'(c_sv), 64'(1'b0));
        check_eq("rstC.last", 64'(c_last), 64'(1'b0));
        check_eq("rstC.pready", 64'(c_pr), 64'(1'b1));

        // ---------------- basic LSB-first ----------------
        a_pv = 1; a_pd = 32'hDDCCBBAA; a_sr = 1;
        step();
        a_pv = 0; a_pd = 32'h0;
        settle();
        chk_a("lsb0", 8'hAA, 2'd0, 1'b0, 1'b0); step();
        chk_a("lsb1", 8'hBB, 2'd1, 1'b0, 1'b0); step();
        chk_a("lsb2", 8'hCC, 2'd2, 1'b0, 1'b0); step();
        chk_a("lsb3", 8'hDD, 2'd3, 1'b1, 1'b1); step();
        settle();
        chk_a_idle("lsbEnd");

        // ---------------- MSB-first ----------------
        b_pv = 1; b_pd = 32'hDDCCBBAA; b_sr = 1;
        step();
        b_pv = 0;
        exp_b = '{8'hDD, 8'hCC, 8'hBB, 8'hAA};
        for (int i = 0; i < 4; i++) begin
            settle();
            check_eq($sformatf("msb%0d.valid", i), 64'(b_sv), 64'(1'b1));
            check_eq($sformatf("msb%0d.data", i), 64'(b_sd), 64'(exp_b[i]));
            check_eq($sformatf("msb%0d.idx", i), 64'(b_idx), 64'(i));
            check_eq($sformatf("msb%0d.last", i), 64'(b_last), 64'(i == 3));
            step();
        end
        settle();
        check_eq("msbEnd.valid", 64'(b_sv), 64'(1'b0));

        // ---------------- backpressure ----------------
        a_pv = 1; a_pd = 32'hDDCCBBAA; a_sr = 1;
        step();
        a_pv = 0;
        settle();
        chk_a("bp0", 8'hAA, 2'd0, 1'b0, 1'b0); step();
        // Stall on beat 1 while upstream offers a word that must be ignored.
        a_sr = 0; a_pv = 1; a_pd = 32'h12345678;
        for (int i = 0; i < 3; i++) begin
            settle();
            chk_a($sformatf("bpHold%0d", i), 8'hBB, 2'd1, 1'b0, 1'b0);
            step();
        end
        a_sr = 1; a_pv = 0; a_pd = '0;
        settle();
        chk_a("bp1", 8'hBB, 2'd1, 1'b0, 1'b0); step();
        chk_a("bp2", 8'hCC, 2'd2, 1'b0, 1'b0); step();
        chk_a("bp3", 8'hDD, 2'd3, 1'b1, 1'b1); step();
        settle();
        chk_a_idle("bpEnd");

        // ---------------- back-to-back ----------------
        exp_a = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66, 8'h77, 8'h88};
        a_pv = 1; a_pd = 32'h44332211; a_sr = 1;
        step();
        a_pd = 32'h88776655;
        for (int i = 0; i < 8; i++) begin
            settle();
            chk_a($sformatf("b2b%0d", i), exp_a[i], 2'(i % 4), (i % 4) == 3, (i % 4) == 3);
            step();
            if (i == 3) begin
                a_pv = 0; a_pd = '0;
            end
        end
        settle();
        chk_a_idle("b2bEnd");

        // ---------------- reset mid-word ----------------
        a_pv = 1; a_pd = 32'hDDCCBBAA; a_sr = 1;
        step();
        a_pv = 0;
        settle();
        chk_a("mr0", 8'hAA, 2'd0, 1'b0, 1'b0); step();
        chk_a("mr1", 8'hBB, 2'd1, 1'b0, 1'b0); step();
        rst = 1;
        step();
        rst = 0;
        settle();
        chk_a_idle("mrRst");
        a_pv = 1; a_pd = 32'h000000EF;
        step();
        a_pv = 0;
        settle();
        chk_a("mrN0", 8'hEF, 2'd0, 1'b0, 1'b0); step();
        chk_a("mrN1", 8'h00, 2'd1, 1'b0, 1'b0); step();
        chk_a("mrN2", 8'h00, 2'd2, 1'b0, 1'b0); step();
        chk_a("mrN3", 8'h00, 2'd3, 1'b1, 1'b1); step();
        settle();
        chk_a_idle("mrEnd");

        // ---------------- degenerate single beat ----------------
        c_pv = 1; c_pd = 8'h01; c_sr = 1;
        step();
        for (int i = 1; i <= 3; i++) begin
            c_pd = 8'(i + 1);
            if (i == 3) c_pv = 0;
            settle();
            check_eq($sformatf("deg%0d.valid", i), 64'(c_sv), 64'(1'b1));
            check_eq($sformatf("deg%0d.data", i), 64'(c_sd), 64'(i));
            check_eq($sformatf("deg%0d.idx", i), 64'(c_idx), 64'(1'b0));
            check_eq($sformatf("deg%0d.last", i), 64'(c_last), 64'(1'b1));
            check_eq($sformatf("deg%0d.pready", i), 64'(c_pr), 64'(1'b1));
            step();
        end
        settle();
        check_eq("degEnd.valid", 64'(c_sv), 64'(1'b0));
        check_eq("degEnd.last", 64'(c_last), 64'(1'b0));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
